// File: rtl/jb_sysref_ctrl.sv
// jb_sysref_ctrl: PL SYSREF sequencing controller.
// Measures the period of an already-synchronised SYSREF and declares lock once it
// has been stable. It then forwards a programmed number of whole SYSREF pulses,
// or a continuous stream, to the DAC and ADC SYSREF outputs.
// All outputs are registered and run in the pl_refclk domain.
module jb_sysref_ctrl #(
    parameter int PERIOD_W   = 16,
    parameter int STABLE_CNT = 4,
    parameter int CNT_W      = 8
) (
    input  logic                pl_refclk,
    input  logic                rst,
    input  logic                sysref_in,
    input  logic                arm,
    input  logic                abort,
    input  logic                continuous,
    input  logic [CNT_W-1:0]    num_pulses,
    input  logic                en_dac,
    input  logic                en_adc,
    input  logic                err_clr,
    output logic                user_sysref_dac,
    output logic                user_sysref_adc,
    output logic [PERIOD_W-1:0] period,
    output logic                locked,
    output logic                busy,
    output logic                done,
    output logic                err_period
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_ARMED     = 3'd2,
        ST_RUN       = 3'd3,
        ST_DONE      = 3'd4
    } state_t;

    localparam logic [PERIOD_W-1:0] PER_MAX    = {PERIOD_W{1'b1}};
    localparam logic [3:0]          STABLE_MAX = 4'(STABLE_CNT);
    localparam logic [CNT_W-1:0]    CNT_MAX    = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]    CNT_ONE    = CNT_W'(1);

    state_t              state_r, state_nxt_s;
    logic                sysref_d_r;
    logic                first_edge_r;
    logic [PERIOD_W-1:0] per_cnt_r;
    logic [PERIOD_W-1:0] period_r;
    logic [3:0]          stable_cnt_r, stable_nxt_s;
    logic [CNT_W-1:0]    pulse_cnt_r, pulse_nxt_s;
    logic                cont_l_r, en_dac_l_r, en_adc_l_r;
    logic [CNT_W-1:0]    num_l_r, num_eff_s;
    logic                rise_s, meas_s, match_s, lock_lost_s, stop_s;
    logic                gate_s, latch_s;
    logic                locked_r, err_r, busy_r, done_r, dac_r, adc_r;

    // Edge detect, measurement qualification and stability bookkeeping
    always_comb begin
        rise_s       = sysref_in & ~sysref_d_r;
        meas_s       = rise_s & first_edge_r;
        match_s      = (per_cnt_r == period_r) && (per_cnt_r != PER_MAX);
        lock_lost_s  = meas_s & ~match_s & locked_r;
        stop_s       = abort | lock_lost_s;
        num_eff_s    = (num_l_r == {CNT_W{1'b0}}) ? CNT_ONE : num_l_r;
        stable_nxt_s = stable_cnt_r;
        if (meas_s) begin
            if (match_s) begin
                if (stable_cnt_r == STABLE_MAX) begin
                    stable_nxt_s = STABLE_MAX;
                end else begin
                    stable_nxt_s = stable_cnt_r + 4'd1;
                end
            end else begin
                stable_nxt_s = 4'd0;
            end
        end else begin
            stable_nxt_s = stable_cnt_r;
        end
    end

    // Sequencer next state, gate and pulse counter; a stop request outranks a rise
    always_comb begin
        state_nxt_s = state_r;
        pulse_nxt_s = pulse_cnt_r;
        gate_s      = 1'b0;
        latch_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (arm) begin
                    latch_s     = 1'b1;
                    state_nxt_s = ST_WAIT_LOCK;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WAIT_LOCK: begin
                if (stop_s) begin
                    state_nxt_s = ST_IDLE;
                end else if (locked_r) begin
                    state_nxt_s = ST_ARMED;
                end else begin
                    state_nxt_s = ST_WAIT_LOCK;
                end
            end
            ST_ARMED: begin
                if (stop_s) begin
                    state_nxt_s = ST_IDLE;
                end else if (rise_s) begin
                    state_nxt_s = ST_RUN;
                    pulse_nxt_s = CNT_ONE;
                    gate_s      = 1'b1;
                end else begin
                    state_nxt_s = ST_ARMED;
                end
            end
            ST_RUN: begin
                if (stop_s) begin
                    state_nxt_s = ST_IDLE;
                end else if (rise_s) begin
                    if (!cont_l_r && (pulse_cnt_r >= num_eff_s)) begin
                        // The closing rise is not forwarded.
                        state_nxt_s = ST_DONE;
                    end else begin
                        gate_s = 1'b1;
                        if (pulse_cnt_r != CNT_MAX) begin
                            pulse_nxt_s = pulse_cnt_r + CNT_ONE;
                        end else begin
                            pulse_nxt_s = pulse_cnt_r;
                        end
                    end
                end else begin
                    gate_s = 1'b1;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Period measurement, lock and sticky lock-loss flag
    always_ff @(posedge pl_refclk or posedge rst) begin
        if (rst) begin
            sysref_d_r   <= 1'b0;
            first_edge_r <= 1'b0;
            per_cnt_r    <= {PERIOD_W{1'b0}};
            period_r     <= {PERIOD_W{1'b0}};
            stable_cnt_r <= 4'd0;
            locked_r     <= 1'b0;
            err_r        <= 1'b0;
        end else begin
            sysref_d_r   <= sysref_in;
            stable_cnt_r <= stable_nxt_s;
            locked_r     <= (stable_nxt_s == STABLE_MAX);
            if (rise_s) begin
                per_cnt_r    <= {{(PERIOD_W-1){1'b0}}, 1'b1};
                first_edge_r <= 1'b1;
            end else if (per_cnt_r != PER_MAX) begin
                per_cnt_r <= per_cnt_r + {{(PERIOD_W-1){1'b0}}, 1'b1};
            end
            if (meas_s && !match_s) begin
                period_r <= per_cnt_r;
            end
            if (lock_lost_s) begin
                err_r <= 1'b1;
            end else if (err_clr) begin
                err_r <= 1'b0;
            end
        end
    end

    // Sequencer state, burst configuration latch and registered outputs
    always_ff @(posedge pl_refclk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            pulse_cnt_r <= {CNT_W{1'b0}};
            cont_l_r    <= 1'b0;
            num_l_r     <= {CNT_W{1'b0}};
            en_dac_l_r  <= 1'b0;
            en_adc_l_r  <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            dac_r       <= 1'b0;
            adc_r       <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            pulse_cnt_r <= pulse_nxt_s;
            if (latch_s) begin
                cont_l_r   <= continuous;
                num_l_r    <= num_pulses;
                en_dac_l_r <= en_dac;
                en_adc_l_r <= en_adc;
            end
            busy_r <= (state_nxt_s != ST_IDLE);
            done_r <= (state_nxt_s == ST_DONE);
            dac_r  <= gate_s & en_dac_l_r & sysref_in;
            adc_r  <= gate_s & en_adc_l_r & sysref_in;
        end
    end

    assign user_sysref_dac = dac_r;
    assign user_sysref_adc = adc_r;
    assign period          = period_r;
    assign locked          = locked_r;
    assign busy            = busy_r;
    assign done            = done_r;
    assign err_period      = err_r;

endmodule

// File: doc/jb_sysref_ctrl.md
Name: jb_sysref_ctrl

Overview:
Sequencing controller for the PL SYSREF path, running in the PL reference clock domain. It takes an already-synchronised SYSREF sample and measures the SYSREF period. It declares lock once the period has been stable, then forwards a programmed number of whole SYSREF pulses (or a continuous stream) to the DAC and ADC SYSREF outputs. It sits between the SYSREF capture flops and the RF converter tiles, and is driven by a software-controlled arm/abort interface.

Parameters:
PERIOD_W, 16, width of the period counter and measured period; the counter saturates at all-ones.
STABLE_CNT, 4, number of consecutive matching period measurements required to declare lock (1..15).
CNT_W, 8, width of the pulse-count request and pulse counter.

Ports:
pl_refclk  input  1  PL reference clock; the only clock.
rst  input  1  reset, asynchronous, active-high.
sysref_in  input  1  SYSREF already registered in the pl_refclk domain.
arm  input  1  single-cycle request to start a burst; accepted only in IDLE.
abort  input  1  single-cycle request to stop; effective in any non-IDLE state.
continuous  input  1  1 = forward pulses until abort; sampled when arm is accepted.
num_pulses  input  CNT_W  burst length; 0 is treated as 1; sampled when arm is accepted.
en_dac  input  1  forward to DAC; sampled when arm is accepted.
en_adc  input  1  forward to ADC; sampled when arm is accepted.
err_clr  input  1  clears err_period.
user_sysref_dac  output  1  gated SYSREF to DAC.
user_sysref_adc  output  1  gated SYSREF to ADC.
period  output  PERIOD_W  last accepted period, in pl_refclk cycles.
locked  output  1  period stable.
busy  output  1  state != IDLE.
done  output  1  one-cycle pulse when a finite burst completes.
err_period  output  1  sticky flag: lock was lost.

Behaviour:
- Reset: all outputs 0, FSM = IDLE, counters 0, first-edge flag cleared.
- Edge detect: sysref_d <= sysref_in; rise = sysref_in & ~sysref_d.
- Period counter per_cnt:
  - On rise, per_cnt <= 1; otherwise it increments, saturating at all-ones.
  - The first rise after reset only sets the first-edge flag.
  - On each later rise, the measurement is m = per_cnt.
- Stability tracking:
  - If m == period and m != all-ones, stable_cnt increments, saturating at STABLE_CNT.
  - Otherwise period <= m and stable_cnt <= 0.
- Lock:
  - locked = (stable_cnt == STABLE_CNT), registered; it rises in the cycle after the qualifying rise.
  - A mismatch while locked=1 drops locked and sets err_period.
- err_period:
  - Cleared by err_clr.
  - If a set and a clear occur in the same cycle, set wins.
- FSM:
  - IDLE: on arm, latch continuous/num_pulses/en_dac/en_adc and go to WAIT_LOCK.
  - WAIT_LOCK: when locked=1, go to ARMED.
  - ARMED: on rise, go to RUN, set pulse_cnt = 1 and open the gate on that same cycle.
  - RUN: on each rise:
    - If continuous=0 and pulse_cnt >= max(num_pulses,1), close the gate (this rise is not forwarded) and go to DONE.
    - Otherwise pulse_cnt increments.
  - DONE: done=1 for one cycle, then go to IDLE.
- Gating and outputs:
  - gate_now = (RUN) | (ARMED & rise), excluding the closing rise.
  - user_sysref_dac <= gate_now & en_dac_l & sysref_in; ADC is identical with en_adc_l.
  - Latency from sysref_in to output is 1 cycle; forwarded pulses are whole pulses at the boundaries.
- abort, or lock loss, in WAIT_LOCK/ARMED/RUN:
  - Go to IDLE and close the gate on the next clock; a pulse in flight may be truncated.
  - done is not asserted.
  - abort has priority over a simultaneous rise.
- arm while busy is ignored; arm and abort together in IDLE means arm.
- Async reset mid-burst forces the outputs low immediately; no done.

Test Plan:
- Lock and 3-pulse burst:
  - Stimulus: SYSREF period 8, high 2 cycles, STABLE_CNT=4; arm with num_pulses=3, en_dac=en_adc=1.
  - Response: period=8; locked 1 cycle after the 5th measured rise; exactly 3 two-cycle pulses on both outputs, 1 cycle delayed; done for 1 cycle after the 4th rise; busy then 0.
- Enable masking and num_pulses=0:
  - Stimulus: arm with en_adc=0, num_pulses=0.
  - Response: 1 pulse on user_sysref_dac; user_sysref_adc stays 0; done asserted.
- Continuous with abort:
  - Stimulus: continuous=1; let 10 pulses pass; assert abort mid-pulse.
  - Response: 10 pulses forwarded; outputs 0 the cycle after abort; no done; busy=0.
- Period change while running:
  - Stimulus: switch SYSREF period from 8 to 12 during RUN.
  - Response: locked=0, err_period=1, return to IDLE, outputs 0; period=12.
  - Follow-up: err_clr clears err_period; lock returns after 4 stable measurements.
- Arm before lock and arm while busy:
  - Stimulus: arm with no SYSREF toggling; then issue a second arm.
  - Response: FSM stays in WAIT_LOCK; the second arm is ignored.
  - Follow-up: start SYSREF; the burst runs with the first arm's num_pulses.
- Saturation and reset:
  - Stimulus: SYSREF period above 2^PERIOD_W−1 cycles; separately, assert rst mid-burst.
  - Response: no lock from the long period; under reset, all outputs 0 immediately and FSM returns to IDLE.
